// File: rtl/accum_atom_pkg.sv
// accum_atom_pkg: width helpers, stage control bundle and latency
// constant shared by the accumulating compute atom and its users.
package accum_atom_pkg;

   localparam int ACCUM_ATOM_LAT = 5;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } stage_ctl_t;

   function automatic int prod_w(input int idataw);
      return 2 * idataw;
   endfunction

   function automatic int tree_w(input int idataw,
                                 input int lanes);
      return prod_w(idataw) + $clog2(lanes);
   endfunction

endpackage

// File: rtl/accum_ofifo.sv
// accum_ofifo: show-ahead FIFO with occupancy count.
// Ports: push_i/wdata_i in, pop_i/rdata_o/valid_o out, count_o level.
module accum_ofifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_pop   = pop_i & (cnt_q != '0);
      do_push  = push_i &
                 ((cnt_q != CNT_W'(DEPTH)) | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ?
                    '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ?
                    '0 : rd_ptr_q + PTR_W'(1);
      end
      if (do_push & !do_pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (do_pop & !do_push) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
         end
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign valid_o = (cnt_q != '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/register_file.sv
// register_file: single write / single registered read weight store.
// Ports: we/waddr/wdata write port, re/raddr read port, rdata_q row out.
module register_file #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 320,
   localparam int ADDRW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ADDRW-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [ADDRW-1:0] raddr,
   output logic [WIDTH-1:0] rdata_q
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Both updates land on the same edge, so a same-row read
   // sees the contents from before the write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

endmodule

// File: rtl/accum_atom.sv
// accum_atom: banked-weight dot-product atom with multi-chunk
// accumulation, valid/ready beat input and credit-gated output FIFO.
// Ports: i_w* weight write, i_raddr/i_vdata/i_first/i_last/i_valid
// beat in with o_ready, o_data/o_valid result out with i_ready.
// Build option ACCUM_ATOM_SAT_EN: saturating accumulator (else wrap).
module accum_atom
   import accum_atom_pkg::*;
#(
   parameter int IDATAW      = 8,
   parameter int LANES       = 40,
   parameter int BATCH       = 1,
   parameter int RF_DEPTH    = 512,
   parameter int ACCW        = 2 * IDATAW + $clog2(LANES) + 8,
   parameter int OFIFO_DEPTH = 4,
   localparam int RF_ADDRW   = $clog2(RF_DEPTH)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [RF_ADDRW-1:0]                   i_waddr,
   input  logic signed [LANES*IDATAW-1:0]        i_wdata,
   input  logic                                  i_wvalid,
   input  logic [RF_ADDRW-1:0]                   i_raddr,
   input  logic signed [BATCH*LANES*IDATAW-1:0]  i_vdata,
   input  logic                                  i_first,
   input  logic                                  i_last,
   input  logic                                  i_valid,
   output logic                                  o_ready,
   output logic signed [BATCH*ACCW-1:0]          o_data,
   output logic                                  o_valid,
   input  logic                                  i_ready
);

   localparam int PW    = prod_w(IDATAW);
   localparam int TW    = tree_w(IDATAW, LANES);
   localparam int CNT_W = $clog2(OFIFO_DEPTH + 1);
   localparam int OCC_W = CNT_W + 3;
   localparam int VW    = BATCH * LANES * IDATAW;

   logic                     accept;
   logic [LANES*IDATAW-1:0]  rf_row;
   logic [VW-1:0]            act_d, act_q;
   stage_ctl_t               s1_d, s1_q;
   stage_ctl_t               s2_d, s2_q;
   stage_ctl_t               s3_d, s3_q;
   logic signed [PW-1:0]     prod_d [BATCH][LANES];
   logic signed [PW-1:0]     prod_q [BATCH][LANES];
   logic signed [TW-1:0]     sum_d  [BATCH];
   logic signed [TW-1:0]     sum_q  [BATCH];
   logic signed [ACCW-1:0]   acc_d  [BATCH];
   logic signed [ACCW-1:0]   acc_q  [BATCH];
   logic                     push_d, push_q;
   logic [BATCH*ACCW-1:0]    push_data;
   logic [CNT_W-1:0]         fifo_cnt;
   logic [2:0]               infl;
   logic [OCC_W-1:0]         occ;

`ifdef ACCUM_ATOM_SAT_EN
   localparam int AW1 = ACCW + 1;
   localparam logic signed [ACCW-1:0] SAT_MAX =
      {1'b0, {(ACCW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SAT_MIN =
      {1'b1, {(ACCW-1){1'b0}}};
`endif

   // Credits: FIFO entries plus last-beats still in flight.
   always_comb begin
      infl = {2'b0, s1_q.valid & s1_q.last} +
             {2'b0, s2_q.valid & s2_q.last} +
             {2'b0, s3_q.valid & s3_q.last} +
             {2'b0, push_q};
      occ  = OCC_W'(fifo_cnt) + OCC_W'(infl);
   end

   assign o_ready = (occ < OCC_W'(OFIFO_DEPTH));
   assign accept  = i_valid & o_ready;

   register_file #(
      .DEPTH (RF_DEPTH),
      .WIDTH (LANES * IDATAW)
   ) u_rf (
      .clk     (clk),
      .we      (i_wvalid),
      .waddr   (i_waddr),
      .wdata   (i_wdata),
      .re      (accept),
      .raddr   (i_raddr),
      .rdata_q (rf_row)
   );

   always_comb begin
      s1_d = '0;
      if (accept) begin
         s1_d.valid = 1'b1;
         s1_d.first = i_first;
         s1_d.last  = i_last;
      end
      act_d = accept ? i_vdata : act_q;
   end

   always_comb begin
      logic signed [IDATAW-1:0] w_v;
      logic signed [IDATAW-1:0] a_v;
      w_v  = '0;
      a_v  = '0;
      s2_d = s1_q;
      for (int b = 0; b < BATCH; b++) begin
         for (int l = 0; l < LANES; l++) begin
            w_v = rf_row[l*IDATAW +: IDATAW];
            a_v = act_q[(b*LANES+l)*IDATAW +: IDATAW];
            prod_d[b][l] = PW'(w_v) * PW'(a_v);
         end
      end
   end

   always_comb begin
      s3_d = s2_q;
      for (int b = 0; b < BATCH; b++) begin
         sum_d[b] = '0;
         for (int l = 0; l < LANES; l++) begin
            sum_d[b] = sum_d[b] + TW'(prod_q[b][l]);
         end
      end
   end

   always_comb begin
`ifdef ACCUM_ATOM_SAT_EN
      logic signed [AW1-1:0] wide_v;
      wide_v = '0;
`endif
      push_d = s3_q.valid & s3_q.last;
      for (int b = 0; b < BATCH; b++) begin
         acc_d[b] = acc_q[b];
         if (s3_q.valid) begin
            if (s3_q.first) begin
               acc_d[b] = ACCW'(sum_q[b]);
            end else begin
`ifdef ACCUM_ATOM_SAT_EN
               wide_v = AW1'(acc_q[b]) + AW1'(sum_q[b]);
               // Top two bits disagree only on overflow.
               if (wide_v[AW1-1] != wide_v[AW1-2]) begin
                  acc_d[b] = wide_v[AW1-1] ? SAT_MIN : SAT_MAX;
               end else begin
                  acc_d[b] = wide_v[ACCW-1:0];
               end
`else
               acc_d[b] = acc_q[b] + ACCW'(sum_q[b]);
`endif
            end
         end
      end
   end

   always_comb begin
      push_data = '0;
      for (int b = 0; b < BATCH; b++) begin
         push_data[b*ACCW +: ACCW] = acc_q[b];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         s3_q   <= '0;
         act_q  <= '0;
         push_q <= 1'b0;
         for (int b = 0; b < BATCH; b++) begin
            sum_q[b] <= '0;
            acc_q[b] <= '0;
            for (int l = 0; l < LANES; l++) begin
               prod_q[b][l] <= '0;
            end
         end
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         s3_q   <= s3_d;
         act_q  <= act_d;
         push_q <= push_d;
         prod_q <= prod_d;
         sum_q  <= sum_d;
         acc_q  <= acc_d;
      end
   end

   accum_ofifo #(
      .WIDTH (BATCH * ACCW),
      .DEPTH (OFIFO_DEPTH)
   ) u_ofifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (push_q),
      .wdata_i (push_data),
      .pop_i   (i_ready),
      .rdata_o (o_data),
      .valid_o (o_valid),
      .count_o (fifo_cnt)
   );

endmodule

// File: tb/tb_accum_atom.sv
// tb_accum_atom: directed scoreboard bench for accum_atom
// (LANES=4, BATCH=2, IDATAW=8, ACCW=18, OFIFO_DEPTH=2).
module tb_accum_atom;
   import accum_atom_pkg::*;

   localparam int IW   = 8;
   localparam int L    = 4;
   localparam int B    = 2;
   localparam int RD   = 16;
   localparam int AW   = 4;
   localparam int ACCW = 18;
   localparam int FD   = 2;
   localparam int RW   = L * IW;
   localparam int VW   = B * L * IW;
   localparam int OW   = B * ACCW;
`ifdef ACCUM_ATOM_SAT_EN
   localparam int E3 = 131071;
`else
   localparam int E3 = -131072;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] i_waddr = '0;
   logic [RW-1:0] i_wdata = '0;
   logic          i_wvalid = 1'b0;
   logic [AW-1:0] i_raddr = '0;
   logic [VW-1:0] i_vdata = '0;
   logic          i_first = 1'b0;
   logic          i_last = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [OW-1:0] o_data;
   logic          o_valid;
   logic          i_ready = 1'b1;

   int            checks = 0;
   int            errors = 0;
   logic [OW-1:0] sb[$];

   always #5 clk = ~clk;

   accum_atom #(
      .IDATAW      (IW),
      .LANES       (L),
      .BATCH       (B),
      .RF_DEPTH    (RD),
      .ACCW        (ACCW),
      .OFIFO_DEPTH (FD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_waddr  (i_waddr),
      .i_wdata  (i_wdata),
      .i_wvalid (i_wvalid),
      .i_raddr  (i_raddr),
      .i_vdata  (i_vdata),
      .i_first  (i_first),
      .i_last   (i_last),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .i_ready  (i_ready)
   );

   function automatic logic [RW-1:0] row4(input int a, input int b,
                                          input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [VW-1:0] vec(input logic [RW-1:0] v0,
                                         input logic [RW-1:0] v1);
      return {v1, v0};
   endfunction

   function automatic logic [OW-1:0] ex(input int e0, input int e1);
      return {18'(e1), 18'(e0)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [RW-1:0] d);
      i_waddr  = AW'(a);
      i_wdata  = d;
      i_wvalid = 1'b1;
      step(1);
      i_wvalid = 1'b0;
   endtask

   task automatic send(input int ra, input logic [VW-1:0] vd,
                       input logic f, input logic la,
                       input logic [OW-1:0] e);
      logic acc;
      acc     = 1'b0;
      i_raddr = AW'(ra);
      i_vdata = vd;
      i_first = f;
      i_last  = la;
      i_valid = 1'b1;
      for (int k = 0; k < 60 && !acc; k++) begin
         @(negedge clk);
         if (o_ready) begin
            acc = 1'b1;
            if (la) sb.push_back(e);
         end
         step(1);
      end
      chk("accept", acc, 1'b1);
   endtask

   // Pops are compared against the scoreboard head; an
   // unexpected pop compares against X and fails.
   always @(negedge clk) begin
      logic [OW-1:0] e;
      if (rst && o_valid && i_ready) begin
         e = 'x;
         if (sb.size() != 0) e = sb.pop_front();
         chk("out_data", o_data, e);
      end
   end

   initial begin
      logic [VW-1:0] ones;
      logic [VW-1:0] neg;
      ones = vec(row4(1, 1, 1, 1), row4(0, 0, 0, 0));
      neg  = vec(row4(-128, -128, -128, -128),
                 row4(-128, -128, -128, -128));
      step(3);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_data", o_data, '0);
      chk("rst_ready", o_ready, 1'b1);
      step(1);

      wr(3, row4(1, 2, 3, 4));
      wr(0, row4(1, 2, 3, 4));
      wr(1, row4(1, 2, 3, 4));
      wr(2, row4(1, 2, 3, 4));
      wr(5, row4(1, 1, 1, 1));
      wr(7, row4(-128, -128, -128, -128));

      // single-chunk job and latency
      send(3, vec(row4(1, 1, 1, 1), row4(2, 0, 0, 0)),
           1'b1, 1'b1, ex(10, 2));
      i_valid = 1'b0;
      step(ACCUM_ATOM_LAT - 2);
      @(negedge clk);
      chk("lat_early", o_valid, 1'b0);
      step(1);
      @(negedge clk);
      chk("lat_t5", o_valid, 1'b1);
      step(8);

      // three-chunk job
      send(0, vec(row4(1, 1, 1, 1), row4(2, 2, 2, 2)),
           1'b1, 1'b0, '0);
      send(1, vec(row4(1, 1, 1, 1), row4(2, 2, 2, 2)),
           1'b0, 1'b0, '0);
      send(2, vec(row4(1, 1, 1, 1), row4(2, 2, 2, 2)),
           1'b0, 1'b1, ex(30, 60));
      i_valid = 1'b0;
      step(10);

      // overflow: wrap or saturate
      send(7, neg, 1'b1, 1'b0, '0);
      send(7, neg, 1'b0, 1'b1, ex(E3, E3));
      i_valid = 1'b0;
      step(10);

      // backpressure with a two-entry FIFO
      i_ready = 1'b0;
      step(1);
      send(3, vec(row4(1, 0, 0, 0), row4(0, 1, 0, 0)),
           1'b1, 1'b1, ex(1, 2));
      send(3, vec(row4(2, 0, 0, 0), row4(0, 2, 0, 0)),
           1'b1, 1'b1, ex(2, 4));
      i_vdata = vec(row4(3, 0, 0, 0), row4(0, 3, 0, 0));
      @(negedge clk);
      chk("bp_ready_drop", o_ready, 1'b0);
      step(8);
      @(negedge clk);
      chk("bp_ready_held", o_ready, 1'b0);
      chk("bp_valid", o_valid, 1'b1);
      chk("bp_hold_data", o_data, ex(1, 2));
      step(1);
      i_ready = 1'b1;
      send(3, vec(row4(3, 0, 0, 0), row4(0, 3, 0, 0)),
           1'b1, 1'b1, ex(3, 6));
      send(3, vec(row4(4, 0, 0, 0), row4(0, 4, 0, 0)),
           1'b1, 1'b1, ex(4, 8));
      i_valid = 1'b0;
      step(12);
      chk("bp_drained", sb.size(), 0);

      // same-cycle write and read of row 5
      i_waddr  = AW'(5);
      i_wdata  = row4(9, 9, 9, 9);
      i_wvalid = 1'b1;
      send(5, ones, 1'b1, 1'b1, ex(4, 0));
      i_wvalid = 1'b0;
      send(5, ones, 1'b1, 1'b1, ex(36, 0));
      i_valid = 1'b0;
      step(10);

      // reset in the middle of a job
      send(0, ones, 1'b1, 1'b0, '0);
      send(1, ones, 1'b0, 1'b0, '0);
      i_valid = 1'b0;
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", o_valid, 1'b0);
      chk("mid_rst_ready", o_ready, 1'b1);
      step(8);
      @(negedge clk);
      chk("mid_rst_quiet", o_valid, 1'b0);
      step(1);
      send(3, vec(row4(1, 1, 1, 1), row4(1, 0, 0, 0)),
           1'b0, 1'b1, ex(10, 1));
      send(3, vec(row4(0, 0, 0, 1), row4(2, 2, 2, 2)),
           1'b1, 1'b1, ex(4, 20));
      i_valid = 1'b0;
      step(12);

      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/accum_atom.md
# accum_atom

Next-generation compute atom. It pairs a banked weight register file with a BATCH-wide dot-product datapath and adds three things the single-shot atom lacks:
- multi-chunk accumulation across successive register-file rows (first/last framing);
- a streamed activation input with valid/ready;
- a credit-controlled output FIFO with backpressure.

It sits between the vector register/loader path and the MVU reduction/output stage of the NPU.

## Interface
Parameters:
- IDATAW, 8: signed weight/activation width.
- LANES, 40: dot-product length per beat.
- BATCH, 1: activation vectors processed per beat against one weight row.
- RF_DEPTH, 512: weight rows.
- ACCW, 2*IDATAW+$clog2(LANES)+8: signed accumulator and output width.
- OFIFO_DEPTH, 4: output FIFO entries, at least 2.
- RF_ADDRW, $clog2(RF_DEPTH): derived; do not override.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-low reset.
- i_waddr, in, RF_ADDRW: weight write row.
- i_wdata, in, IDATAW x LANES (signed): weight row data.
- i_wvalid, in, 1: write strobe.
- i_raddr, in, RF_ADDRW: weight row for this beat.
- i_vdata, in, IDATAW x LANES x BATCH (signed): activations.
- i_first, in, 1: beat starts a new accumulation.
- i_last, in, 1: beat ends the accumulation and emits a result.
- i_valid, in, 1: beat valid.
- o_ready, out, 1: beat accepted when i_valid & o_ready.
- o_data, out, ACCW x BATCH (signed): result, one per batch element.
- o_valid, out, 1: result valid.
- i_ready, in, 1: downstream accepts.

## Operation
- Weight writes:
  - Independent of the compute path; accepted every cycle.
  - Write and read to the same row in the same cycle return the old data (read-before-write).
- Compute pipeline for an accepted beat at cycle t:
  - S1 (t+1): RF row read; activations registered.
  - S2 (t+2): LANES x BATCH signed products registered, each 2*IDATAW bits.
  - S3 (t+3): per-batch adder-tree sum registered, 2*IDATAW+$clog2(LANES) bits, full precision and sign-extended.
  - S4 (t+4): accumulator update, per batch element.
- Accumulator update rules:
  - If first, acc = sum; else acc = acc + sum.
  - first and last may both be set on the same beat (single-chunk job).
  - A beat without first following a completed job accumulates onto the stale value. This is not flagged; framing is upstream's responsibility.
- Result push: if last, the updated accumulator value (not the pre-update value) is pushed into the output FIFO at t+4.
- Arithmetic: two's-complement wrap at ACCW by default (see Configuration).
- Flow control:
  - o_ready = (fifo_count + inflight_last) < OFIFO_DEPTH.
  - inflight_last counts last-beats in S1..S4.
  - The FIFO therefore never overflows, and the pipeline never stalls once a beat is accepted.
  - Non-last beats are also blocked while o_ready is low.
- Output FIFO: show-ahead. o_valid = !empty. Pop on o_valid & i_ready. Push and pop in the same cycle leave the count unchanged.
- Reset: clears all pipeline valids, inflight_last, the FIFO pointers/count and the accumulators. Register-file contents are not reset. A reset asserted mid-job discards all partial results.

## Timing
- Reset values: o_valid=0, o_data=0, o_ready=1 (after reset deasserts).
- Latency from accepted single-chunk beat to o_valid is 5 cycles with an empty FIFO (t+5).
- Throughput: 1 beat/cycle while o_ready=1.
- o_ready depends only on registered state; no combinational path from i_valid or i_ready.
- o_data is held stable while o_valid & !i_ready.

## Configuration
- ACCUM_ATOM_SAT_EN:
  - Defined: S4 saturates to [-2^(ACCW-1), 2^(ACCW-1)-1] on overflow; the saturated value persists and is accumulated further.
  - Undefined: wrap-around, with no saturation logic present.

## Structure
- Package accum_atom_pkg holds:
  - width-derivation functions (product width, tree width);
  - the pipeline-stage valid/first/last struct typedef;
  - the latency constant ACCUM_ATOM_LAT = 5.
- The existing register_file module is reused.
- One new sub-module, accum_ofifo: a parametrised show-ahead FIFO with count output.

## Test plan
Configuration: LANES=4, BATCH=2, IDATAW=8.
1. Row 3 = {1,2,3,4}; beat raddr=3, vdata b0={1,1,1,1}, b1={2,0,0,0}, first=last=1 -> o_data {10,2}, o_valid at t+5.
2. Rows 0..2 = {1,2,3,4}; three beats, first on beat 1, last on beat 3, vdata b0 all 1 -> single result b0=30; no output on beats 1-2.
3. ACCW=18, weights and activations all -128, two-beat job:
   - Without the macro -> b0=-131072 (wrap).
   - With ACCUM_ATOM_SAT_EN -> 131071.
4. OFIFO_DEPTH=2, i_ready=0, four single-chunk jobs offered back-to-back -> o_ready drops after the 2nd accept. Release i_ready -> the 4 results appear in order, none lost or duplicated.
5. Write row 5 = {9,9,9,9} in the same cycle as a beat reads row 5 (old row {1,1,1,1}, vdata all 1) -> result 4. The next beat on row 5 -> 36.
6. Assert rst two cycles into a three-beat job -> o_valid=0 and o_ready=1 after release. A new single-chunk job yields a correct sum with no carry-over.
